bc_reader: RTL
==============

BC_READER -- requirements
Module: bc_reader

Interface
REQ-001 Parameter CNT_W, default 22, width of the pulse-timing counter.
REQ-002 Parameter SYNC_STAGES, default 2, number of flops synchronizing BC.
REQ-003 Parameter TMO_CYC, default 2^CNT_W-1, idle-high cycles that abort a frame in progress.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 BC  input  1  asynchronous barcode serial line; idles high.
REQ-007 clr_ID_vld  input  1  one-cycle pulse from consumer acknowledging ID.
REQ-008 ID  output  8  last accepted station ID.
REQ-009 ID_vld  output  1  sticky flag: ID holds a new accepted value.
REQ-010 busy  output  1  high while a frame is being received.

Function
REQ-011 BC shall pass through SYNC_STAGES flops, plus one extra flop for edge detection; a falling edge is synced==0 while previous==1.
REQ-012 Frame format: start bit, then 8 data bits MSB first. Each bit begins with a falling edge. The start bit is low for a reference time T. A data bit is 1 if BC is high T cycles after its falling edge, else 0.
REQ-013 States: IDLE, START (measure T), WAIT_FALL (await next bit edge), DELAY (count T, then sample).
REQ-014 IDLE -> START on a falling edge, with busy=1, the timer cleared and the bit counter cleared.
REQ-015 In START, the timer shall increment each low cycle, saturating at 2^CNT_W-1. On the synced rising edge, T shall latch the timer value and the state shall go to WAIT_FALL.
REQ-016 WAIT_FALL -> DELAY on a falling edge, with the timer cleared.
REQ-017 In DELAY, when timer==T the synced BC shall be shifted into the shift register LSB, the bit counter shall increment, and the state shall go to WAIT_FALL, or to IDLE after the 8th bit.
REQ-018 On completing 8 bits: if shift[7:6]==2'b00, then ID<=shift and ID_vld<=1; otherwise ID and ID_vld are unchanged (frame discarded).
REQ-019 Latency from the 8th sample cycle to ID_vld high shall be exactly 1 clk.
REQ-020 clr_ID_vld shall clear ID_vld on the next edge; if a set and a clear occur in the same cycle, the set wins.
REQ-021 A new accepted frame while ID_vld=1 shall overwrite ID, and ID_vld shall stay 1.
REQ-022 In WAIT_FALL, if TMO_CYC cycles pass without a falling edge, the FSM shall return to IDLE, discard partial data and drop busy.
REQ-023 A start-bit low time of 0 is impossible because of edge detection; T==2^CNT_W-1 (saturated) shall abort to IDLE.
REQ-024 busy shall be low only in IDLE.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, ID=8'h00, ID_vld=0, busy=0, and the timer, T, shift register, bit counter and sync flops are all set to the idle level (sync flops=1).
REQ-026 rst asserted mid-frame shall abandon the frame with no ID_vld pulse.
REQ-027 After rst deasserts, a BC that is already low shall not start a frame until a true falling edge is seen.

Structure
REQ-028 The state enum and the constants ID_BITS=8 and ID_VALID_MASK=2'b00 shall live in the shared package follower_pkg.
REQ-029 The synchronizer plus edge detector shall be one sub-module, bc_sync_edge (params SYNC_STAGES; outputs synced level and fall pulse).
REQ-030 The timer and T register shall each be CNT_W bits wide, with no signed arithmetic.

Verification
REQ-031 Period 0x20A, ID 0x25 -> ID_vld rises 1 clk after the 8th sample, ID=8'h25, busy falls the same cycle.
REQ-032 Period 0x20A, ID 0xC5 -> ID_vld stays 0 and ID is unchanged (8'h00 after reset).
REQ-033 ID 0x12 accepted, then clr_ID_vld pulsed in the same cycle as a second frame 0x3A completes -> ID_vld=1, ID=8'h3A.
REQ-034 rst asserted after the 4th data bit of ID 0x25 -> ID=8'h00, ID_vld=0, busy=0; the next full frame 0x07 is accepted correctly.
REQ-035 Start bit plus 3 bits, then BC held high for TMO_CYC (bench sets CNT_W=10, TMO_CYC=1000) -> busy drops, ID_vld=0; the next frame 0x11 is accepted.
REQ-036 Two back-to-back frames, period 0x40, IDs 0x01 then 0x3F, with no clear between them -> ID_vld stays 1 and the final ID=8'h3F.

Source files
------------

// File: rtl/follower_pkg.sv
// Shared types and constants for the barcode reader: FSM state encoding
// and the rule deciding which received bytes count as valid station IDs.
package follower_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_FALL,
      DELAY
   } state_t;

   localparam int         ID_BITS       = 8;
   localparam logic [1:0] ID_VALID_MASK = 2'b00;

   // A byte is a station ID only when its two top bits match the mask.
   function automatic logic id_accept(input logic [ID_BITS-1:0] value);
      return value[ID_BITS-1 -: 2] == ID_VALID_MASK;
   endfunction

endpackage

// File: rtl/bc_sync_edge.sv
// Synchronizes the asynchronous BC line and flags its falling and rising
// edges; edges are suppressed until the chain holds only post-reset samples.
module bc_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic bc,
   output logic synced,
   output logic fall,
   output logic rise
);

   localparam int FILL_CYC = SYNC_STAGES + 1;
   localparam int FILL_W   = $clog2(FILL_CYC + 1);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;
   logic [FILL_W-1:0]      fill_cnt;
   logic                   armed;

   // Reset values mimic an idle-high line; the reset value itself must not
   // later appear as a falling edge if BC was already low.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain    <= '1;
         prev     <= 1'b1;
         fill_cnt <= '0;
      end else begin
         chain[0] <= bc;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= chain[SYNC_STAGES-1];
         if (!armed) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

   assign armed  = (fill_cnt == FILL_W'(FILL_CYC));
   assign synced = chain[SYNC_STAGES-1];
   assign fall   = armed & ~synced & prev;
   assign rise   = armed & synced & ~prev;

endmodule

// File: rtl/bc_reader.sv
// Barcode frame receiver: measures the start-bit low time T, then samples
// each data bit T cycles after its falling edge and publishes accepted IDs.
module bc_reader
   import follower_pkg::*;
#(
   parameter int CNT_W       = 22,
   parameter int SYNC_STAGES = 2,
   parameter int TMO_CYC     = 2**CNT_W - 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               BC,
   input  logic               clr_ID_vld,
   output logic [ID_BITS-1:0] ID,
   output logic               ID_vld,
   output logic               busy
);

   localparam int               BIT_W   = $clog2(ID_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TMO_END = CNT_W'(TMO_CYC - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ID_BITS - 1);

   state_t             state;
   logic [CNT_W-1:0]   timer;
   logic [CNT_W-1:0]   t_ref;
   logic [ID_BITS-1:0] shift;
   logic [ID_BITS-1:0] next_shift;
   logic [BIT_W-1:0]   bit_cnt;
   logic               synced;
   logic               fall;
   logic               rise;

   bc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .bc    (BC),
      .synced(synced),
      .fall  (fall),
      .rise  (rise)
   );

   assign next_shift = {shift[ID_BITS-2:0], synced};

   // The timer is shared: start-bit length in START, sample delay in DELAY,
   // and idle-high timeout in WAIT_FALL. A clear and a set of ID_vld in the
   // same cycle resolve to set because the set is written last.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         t_ref   <= '0;
         shift   <= '0;
         bit_cnt <= '0;
         ID      <= '0;
         ID_vld  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         if (clr_ID_vld) begin
            ID_vld <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (fall) begin
                  state   <= START;
                  busy    <= 1'b1;
                  timer   <= '0;
                  bit_cnt <= '0;
                  shift   <= '0;
               end
            end
            START: begin
               if (timer == CNT_MAX) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (rise) begin
                  t_ref <= timer;
                  timer <= '0;
                  state <= WAIT_FALL;
               end else if (!synced) begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_FALL: begin
               if (fall) begin
                  timer <= '0;
                  state <= DELAY;
               end else if (timer == TMO_END) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DELAY: begin
               if (timer == t_ref) begin
                  shift   <= next_shift;
                  bit_cnt <= bit_cnt + 1'b1;
                  timer   <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     if (id_accept(next_shift)) begin
                        ID     <= next_shift;
                        ID_vld <= 1'b1;
                     end
                  end else begin
                     state <= WAIT_FALL;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
